secuenciador_alu: RTL and testbench
===================================

// Module: secuenciador_alu
// PURPOSE
//  Clocked controller that sequences operand and opcode loading for the ALU from a
//  single data-switch bus and two push buttons. It replaces level-sensitive loading
//  with a debounced, edge-triggered FSM: A, then B, then OP, then result-valid.
//  It sits between the board switches/buttons and the ALU operand/opcode inputs.
// PARAMETERS
//  DAT_W   8  width of entrada, a, b (matches `BUS_DAT_MSB+1)
//  OP_W    6  width of op (matches `BUS_OP_MSB+1); OP_W <= DAT_W
//  DEB_N   3  consecutive cycles a synchronized button level must differ to be accepted (>=1)
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      asynchronous, active-high reset
//  entrada     in   DAT_W  data switches
//  boton_carga in   1      load/advance button, raw asynchronous level
//  boton_clr   in   1      clear button, raw asynchronous level
//  a           out  DAT_W  operand A (registered)
//  b           out  DAT_W  operand B (registered)
//  op          out  OP_W   opcode (registered)
//  estado      out  2      FSM state: 00 S_A, 01 S_B, 10 S_OP, 11 S_RES
//  listo       out  1      operands and opcode complete; ALU output is valid
// BEHAVIOUR
//  Reset (async, any time incl. mid-sequence): a=0, b=0, op=0, estado=S_A, listo=0;
//   synchronizers, debounce counters and accepted levels = 0.
//  Per button: 2-FF synchronizer -> debouncer -> rising-edge detector.
//   Debounce: counter counts edges where sync level != accepted level; clears to 0
//   when they match. When count reaches DEB_N, accepted level takes sync level, count=0.
//   A glitch shorter than DEB_N cycles at sync output is ignored.
//   Press event = accepted level 0->1; exactly one cycle; release generates nothing.
//  Latency: raw button high sampled at edge 0 and held -> register/state update at
//   edge 2+DEB_N+1 (edge 6 for DEB_N=3). Holding the button gives a single event.
//  FSM, on carga event (clr event absent):
//   S_A  : a<=entrada, -> S_B
//   S_B  : b<=entrada, -> S_OP
//   S_OP : op<=entrada[OP_W-1:0], listo<=1, -> S_RES
//   S_RES: a<=entrada, listo<=0, -> S_B (next operation starts; b, op hold old values)
//  clr event, any state: a,b,op<=0, listo<=0, -> S_A. Same-cycle carga+clr: clr wins,
//   carga is discarded.
//  No event: all outputs hold. entrada changes never affect outputs without an event.
//  Button held high through reset release: accepted level starts 0, so one press event
//   occurs DEB_N+2 cycles after release (defined behaviour, not an error).
//  listo is 1 only in S_RES; estado always reflects the current state register.
// TESTING
//  1 Reset, entrada=8'h12 carga, 8'h34 carga, 8'h05 carga -> a=12,b=34,op=05,
//    estado=11, listo=1; each update exactly 6 edges after press sampled.
//  2 carga pulse 2 cycles wide (DEB_N=3) -> no event; estado, a unchanged.
//  3 In S_RES, entrada=8'hAA carga -> a=AA, b=34, op=05 kept, listo=0, estado=01.
//  4 In S_OP, carga and clr pressed together -> a=b=op=0, estado=00, listo=0.
//  5 Assert reset while in S_B with carga mid-debounce -> all outputs 0, estado=00,
//    no event after reset release unless button still held (then one event at +5).
//  6 Hold carga 50 cycles with 4 bounces <3 cycles on release -> exactly one load.

Source files
------------

// File: rtl/secuenciador_alu_if.sv
// Operand/opcode sequencer bus: board switches and buttons in, ALU operands out.
interface secuenciador_alu_if #(
  parameter int unsigned DAT_W = 8,
  parameter int unsigned OP_W  = 6
);
  logic [DAT_W-1:0] entrada;
  logic             boton_carga;
  logic             boton_clr;
  logic [DAT_W-1:0] a;
  logic [DAT_W-1:0] b;
  logic [OP_W-1:0]  op;
  logic [1:0]       estado;
  logic             listo;

  // Board side: drives switches and buttons, observes the loaded operands.
  modport master (
    output entrada, boton_carga, boton_clr,
    input  a, b, op, estado, listo
  );

  // Sequencer side.
  modport slave (
    input  entrada, boton_carga, boton_clr,
    output a, b, op, estado, listo
  );
endinterface

// File: rtl/secuenciador_alu.sv
// ALU operand/opcode sequencer: debounced, edge-triggered loading of A, B and OP
// from a single switch bus, with a clear button that returns to the start.
module secuenciador_alu #(
  parameter int unsigned DAT_W = 8,
  parameter int unsigned OP_W  = 6,
  parameter int unsigned DEB_N = 3
) (
  input logic              clk,
  input logic              reset,
  secuenciador_alu_if.slave bus
);

  localparam int unsigned CW = (DEB_N > 1) ? $clog2(DEB_N) : 1;

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_OP  = 2'b10,
    S_RES = 2'b11
  } state_t;

  // Button index 0 = carga, 1 = clr.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    acc;
  logic [1:0]    acc_d;
  logic [1:0]    press;
  logic [CW-1:0] cnt [2];

  state_t           state;
  logic [DAT_W-1:0] a_q;
  logic [DAT_W-1:0] b_q;
  logic [OP_W-1:0]  op_q;
  logic             listo_q;

  assign raw = {bus.boton_clr, bus.boton_carga};

  // Synchronize, debounce and detect the accepted-level rising edge of each button.
  // The press pulse is registered, so a held button reaches the FSM 2+DEB_N+1 edges
  // after it is first sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      acc    <= '0;
      acc_d  <= '0;
      press  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      acc_d <= acc;
      press <= acc & ~acc_d;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == acc[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEB_N - 1)) begin
          acc[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Load sequence A -> B -> OP -> result; clear overrides a simultaneous load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      listo_q <= 1'b0;
    end else if (press[1]) begin
      state   <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      listo_q <= 1'b0;
    end else if (press[0]) begin
      case (state)
        S_A: begin
          a_q   <= bus.entrada;
          state <= S_B;
        end
        S_B: begin
          b_q   <= bus.entrada;
          state <= S_OP;
        end
        S_OP: begin
          op_q    <= bus.entrada[OP_W-1:0];
          listo_q <= 1'b1;
          state   <= S_RES;
        end
        S_RES: begin
          a_q     <= bus.entrada;
          listo_q <= 1'b0;
          state   <= S_B;
        end
        default: state <= S_A;
      endcase
    end
  end

  assign bus.a      = a_q;
  assign bus.b      = b_q;
  assign bus.op     = op_q;
  assign bus.estado = state;
  assign bus.listo  = listo_q;

endmodule

// File: tb/tb_secuenciador_alu.sv
// Directed bench for secuenciador_alu with DEB_N=3 (press-to-update latency 6 edges).
module tb_secuenciador_alu;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  secuenciador_alu_if #(.DAT_W(8), .OP_W(6)) bus ();

  secuenciador_alu #(.DAT_W(8), .OP_W(6), .DEB_N(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                         input logic [5:0] eop, input logic [1:0] eest, input logic el);
    chk({tag, ".a"}, bus.a, ea);
    chk({tag, ".b"}, bus.b, eb);
    chk({tag, ".op"}, {2'b00, bus.op}, {2'b00, eop});
    chk({tag, ".estado"}, {6'd0, bus.estado}, {6'd0, eest});
    chk({tag, ".listo"}, {7'd0, bus.listo}, {7'd0, el});
  endtask

  // Press carga with entrada=d, check hold at edge 5 and update at edge 6, then release.
  task automatic load(input string tag, input logic [7:0] d,
                      input logic [7:0] pa, input logic [7:0] pb, input logic [5:0] pop,
                      input logic [1:0] pest, input logic pl,
                      input logic [7:0] na, input logic [7:0] nb, input logic [5:0] nop,
                      input logic [1:0] nest, input logic nl);
    bus.entrada = d;
    bus.boton_carga = 1'b1;
    step(6);
    chk_all({tag, "@5"}, pa, pb, pop, pest, pl);
    step(1);
    chk_all({tag, "@6"}, na, nb, nop, nest, nl);
    bus.boton_carga = 1'b0;
    step(8);
  endtask

  initial begin
    bus.entrada = 8'h00;
    bus.boton_carga = 1'b0;
    bus.boton_clr = 1'b0;
    step(2);
    chk_all("reset", 8'h00, 8'h00, 6'h00, 2'b00, 1'b0);
    reset = 1'b0;
    step(2);

    // Full A, B, OP sequence
    load("ldA", 8'h12, 8'h00, 8'h00, 6'h00, 2'b00, 1'b0, 8'h12, 8'h00, 6'h00, 2'b01, 1'b0);
    load("ldB", 8'h34, 8'h12, 8'h00, 6'h00, 2'b01, 1'b0, 8'h12, 8'h34, 6'h00, 2'b10, 1'b0);
    load("ldOP", 8'h05, 8'h12, 8'h34, 6'h00, 2'b10, 1'b0, 8'h12, 8'h34, 6'h05, 2'b11, 1'b1);

    // Two-cycle pulse is a glitch; entrada changes alone do nothing
    bus.entrada = 8'hFF;
    bus.boton_carga = 1'b1;
    step(2);
    bus.boton_carga = 1'b0;
    step(12);
    chk_all("glitch", 8'h12, 8'h34, 6'h05, 2'b11, 1'b1);

    // S_RES load starts next operation
    load("ldRES", 8'hAA, 8'h12, 8'h34, 6'h05, 2'b11, 1'b1, 8'hAA, 8'h34, 6'h05, 2'b01, 1'b0);
    load("ldB2", 8'h56, 8'hAA, 8'h34, 6'h05, 2'b01, 1'b0, 8'hAA, 8'h56, 6'h05, 2'b10, 1'b0);

    // carga and clr together in S_OP: clear wins
    bus.entrada = 8'h3F;
    bus.boton_carga = 1'b1;
    bus.boton_clr = 1'b1;
    step(6);
    chk_all("both@5", 8'hAA, 8'h56, 6'h05, 2'b10, 1'b0);
    step(1);
    chk_all("both@6", 8'h00, 8'h00, 6'h00, 2'b00, 1'b0);
    bus.boton_carga = 1'b0;
    bus.boton_clr = 1'b0;
    step(8);
    chk_all("both_rel", 8'h00, 8'h00, 6'h00, 2'b00, 1'b0);

    // Reset in S_B with carga mid-debounce, button released during reset
    load("ldA2", 8'h77, 8'h00, 8'h00, 6'h00, 2'b00, 1'b0, 8'h77, 8'h00, 6'h00, 2'b01, 1'b0);
    bus.entrada = 8'h88;
    bus.boton_carga = 1'b1;
    step(3);
    reset = 1'b1;
    #1;
    chk_all("rst_mid", 8'h00, 8'h00, 6'h00, 2'b00, 1'b0);
    bus.boton_carga = 1'b0;
    step(2);
    reset = 1'b0;
    step(12);
    chk_all("rst_nohold", 8'h00, 8'h00, 6'h00, 2'b00, 1'b0);

    // Button held through reset release: one press after release
    bus.entrada = 8'h3C;
    bus.boton_carga = 1'b1;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(6);
    chk_all("hold_rst@5", 8'h00, 8'h00, 6'h00, 2'b00, 1'b0);
    step(1);
    chk_all("hold_rst@6", 8'h3C, 8'h00, 6'h00, 2'b01, 1'b0);
    bus.boton_carga = 1'b0;
    step(8);

    // Long hold with bouncy release: exactly one load
    bus.entrada = 8'h99;
    bus.boton_carga = 1'b1;
    step(50);
    chk_all("long_hold", 8'h3C, 8'h99, 6'h00, 2'b10, 1'b0);
    bus.boton_carga = 1'b0; step(1);
    bus.boton_carga = 1'b1; step(2);
    bus.boton_carga = 1'b0; step(2);
    bus.boton_carga = 1'b1; step(1);
    bus.boton_carga = 1'b0; step(1);
    bus.boton_carga = 1'b1; step(2);
    bus.boton_carga = 1'b0; step(1);
    bus.boton_carga = 1'b1; step(2);
    bus.boton_carga = 1'b0;
    step(12);
    chk_all("bounce", 8'h3C, 8'h99, 6'h00, 2'b10, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
